// File: rtl/arm_pkg.sv
// Shared ARM-subset pipeline types.
//   exe_cmd_t : 4-bit ALU command encoding
//   ctrl_t    : control bundle carried from ID to EXE
//   id_exe_t  : operand / immediate / register-index bundle carried from ID to EXE
package arm_pkg;

  localparam int unsigned ARM_DW = 32;
  localparam int unsigned ARM_RW = 4;

  typedef enum logic [3:0] {
    EXE_NOP = 4'b0000,
    EXE_MOV = 4'b0001,
    EXE_ADD = 4'b0010,
    EXE_ADC = 4'b0011,
    EXE_SUB = 4'b0100,
    EXE_SBC = 4'b0101,
    EXE_AND = 4'b0110,
    EXE_ORR = 4'b0111,
    EXE_EOR = 4'b1000,
    EXE_MVN = 4'b1001
  } exe_cmd_t;

  typedef struct packed {
    exe_cmd_t exe_cmd;
    logic     mem_r_en;
    logic     mem_w_en;
    logic     wb_en;
    logic     b;
    logic     s;
  } ctrl_t;

  typedef struct packed {
    logic [ARM_DW-1:0] pc;
    logic [ARM_DW-1:0] val_rn;
    logic [ARM_DW-1:0] val_rm;
    logic              imm;
    logic [11:0]       shift_op;
    logic [23:0]       simm24;
    logic [ARM_RW-1:0] dest;
    logic [ARM_RW-1:0] src1;
    logic [ARM_RW-1:0] src2;
    logic              c;
  } id_exe_t;

endpackage

// File: rtl/id_exe_reg_pipe_reg.sv
// Generic W-bit pipeline register.
//   clk : rising-edge clock
//   rst : synchronous active-high reset to 0
//   en  : 1 = update, 0 = hold (hold wins over clr)
//   clr : when enabled, load 0 instead of d
//   d/q : data in / registered data out
module pipe_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (en) begin
      q_d = clr ? '0 : d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/id_exe_reg.sv
// ID/EXE pipeline register with freeze (memory stall), flush (taken branch),
// valid tracking and saturating flush/stall performance counters.
//   clk, rst          : rising-edge clock, synchronous active-high reset
//   freeze            : hold all state (beats flush)
//   flush             : load a bubble on the next unfrozen edge
//   *_in / *_out      : control, operand and field inputs and their registered copies
//   valid_out         : 1 = EXE holds a real instruction
//   flush_cnt         : number of flush edges taken (saturating)
//   stall_cnt         : number of frozen cycles (saturating)
module id_exe_reg
  import arm_pkg::*;
#(
  parameter int unsigned DW    = ARM_DW,
  parameter int unsigned RW    = ARM_RW,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             flush,
  input  logic [3:0]       exe_cmd_in,
  input  logic             mem_r_en_in,
  input  logic             mem_w_en_in,
  input  logic             wb_en_in,
  input  logic             b_in,
  input  logic             s_in,
  input  logic [DW-1:0]    pc_in,
  input  logic [DW-1:0]    val_rn_in,
  input  logic [DW-1:0]    val_rm_in,
  input  logic             imm_in,
  input  logic [11:0]      shift_op_in,
  input  logic [23:0]      simm24_in,
  input  logic [RW-1:0]    dest_in,
  input  logic [RW-1:0]    src1_in,
  input  logic [RW-1:0]    src2_in,
  input  logic             c_in,
  output logic [3:0]       exe_cmd_out,
  output logic             mem_r_en_out,
  output logic             mem_w_en_out,
  output logic             wb_en_out,
  output logic             b_out,
  output logic             s_out,
  output logic [DW-1:0]    pc_out,
  output logic [DW-1:0]    val_rn_out,
  output logic [DW-1:0]    val_rm_out,
  output logic             imm_out,
  output logic [11:0]      shift_op_out,
  output logic [23:0]      simm24_out,
  output logic [RW-1:0]    dest_out,
  output logic [RW-1:0]    src1_out,
  output logic [RW-1:0]    src2_out,
  output logic             c_out,
  output logic             valid_out,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  ctrl_t   ctrl_d;
  ctrl_t   ctrl_q;
  id_exe_t data_d;
  id_exe_t data_q;

  logic             en;
  logic             valid_q,     valid_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  assign en = ~freeze;

  always_comb begin
    ctrl_d          = '0;
    ctrl_d.exe_cmd  = exe_cmd_t'(exe_cmd_in);
    ctrl_d.mem_r_en = mem_r_en_in;
    ctrl_d.mem_w_en = mem_w_en_in;
    ctrl_d.wb_en    = wb_en_in;
    ctrl_d.b        = b_in;
    ctrl_d.s        = s_in;
  end

  always_comb begin
    data_d          = '0;
    data_d.pc       = pc_in;
    data_d.val_rn   = val_rn_in;
    data_d.val_rm   = val_rm_in;
    data_d.imm      = imm_in;
    data_d.shift_op = shift_op_in;
    data_d.simm24   = simm24_in;
    data_d.dest     = dest_in;
    data_d.src1     = src1_in;
    data_d.src2     = src2_in;
    data_d.c        = c_in;
  end

  pipe_reg #(.W($bits(ctrl_t))) u_ctrl_reg (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .clr (flush),
    .d   (ctrl_d),
    .q   (ctrl_q)
  );

  pipe_reg #(.W($bits(id_exe_t))) u_data_reg (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .clr (flush),
    .d   (data_d),
    .q   (data_q)
  );

  // An all-zero control bundle is a bubble from the control unit or hazard mux,
  // so it never marks EXE as holding a real instruction.
  always_comb begin
    valid_d     = valid_q;
    flush_cnt_d = flush_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (freeze) begin
      if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else if (flush) begin
      valid_d = 1'b0;
      if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end else begin
      valid_d = (ctrl_d != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      flush_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      flush_cnt_q <= flush_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign exe_cmd_out  = ctrl_q.exe_cmd;
  assign mem_r_en_out = ctrl_q.mem_r_en;
  assign mem_w_en_out = ctrl_q.mem_w_en;
  assign wb_en_out    = ctrl_q.wb_en;
  assign b_out        = ctrl_q.b;
  assign s_out        = ctrl_q.s;
  assign pc_out       = data_q.pc;
  assign val_rn_out   = data_q.val_rn;
  assign val_rm_out   = data_q.val_rm;
  assign imm_out      = data_q.imm;
  assign shift_op_out = data_q.shift_op;
  assign simm24_out   = data_q.simm24;
  assign dest_out     = data_q.dest;
  assign src1_out     = data_q.src1;
  assign src2_out     = data_q.src2;
  assign c_out        = data_q.c;
  assign valid_out    = valid_q;
  assign flush_cnt    = flush_cnt_q;
  assign stall_cnt    = stall_cnt_q;

endmodule
